// File: rtl/seq_mon_pkg.sv
// Shared types and default parameters for the sequence-hit window monitor.
package seq_mon_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_e;

  localparam int DEF_WINDOW_LEN = 64;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_THRESH     = 4;

  // Width of a cycle counter that must reach n-1.
  function automatic int cyc_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_hit_window_monitor_if.sv
// Report channel: one window result offered under valid/ready.
interface seq_hit_window_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_alarm;

  modport master (output rpt_valid, output rpt_count, output rpt_alarm, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_count, input rpt_alarm, output rpt_ready);
endinterface

// File: rtl/seq_mon_report_slot.sv
// One-entry valid/ready holding register; contents never change while valid and not taken.
module seq_mon_report_slot #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              can_load
);

  assign can_load = ~valid | ready;

  // Slot register: load wins over drain, so a same-cycle take-and-refill keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && can_load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_hit_window_monitor.sv
// Counts detector pulses over back-to-back fixed windows and reports count plus alarm per window.
module seq_hit_window_monitor
  import seq_mon_pkg::*;
#(
  parameter int WINDOW_LEN = DEF_WINDOW_LEN,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int THRESH     = DEF_THRESH
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic hit,
  input  logic clr_dropped,
  output logic dropped,
  seq_hit_window_monitor_if.master rpt
);

  localparam int               CYC_W    = cyc_width(WINDOW_LEN);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  mon_state_e       state_r, state_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic [CNT_W-1:0] hit_cnt_r, hit_cnt_s, final_s;
  logic             win_end_s, alarm_s, load_s, drop_s, can_load_s, dropped_r;
  logic [CNT_W:0]   slot_in_s, slot_q_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_W'(1'b1);
    end else begin
      return v;
    end
  endfunction

  // Next-state, window position and hit accumulation; final_s already includes this cycle's hit.
  always_comb begin
    state_s   = state_r;
    cyc_s     = cyc_r;
    hit_cnt_s = hit_cnt_r;
    win_end_s = 1'b0;
    final_s   = sat_inc(hit_cnt_r, hit);
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s   = RUN;
          cyc_s     = CYC_W'(1'b1);
          hit_cnt_s = final_s;
        end else begin
          cyc_s     = '0;
          hit_cnt_s = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_s   = IDLE;
          cyc_s     = '0;
          hit_cnt_s = '0;
        end else if (cyc_r == LAST_CYC) begin
          win_end_s = 1'b1;
          cyc_s     = '0;
          hit_cnt_s = '0;
        end else begin
          cyc_s     = cyc_r + CYC_W'(1'b1);
          hit_cnt_s = final_s;
        end
      end
      default: begin
        state_s   = IDLE;
        cyc_s     = '0;
        hit_cnt_s = '0;
      end
    endcase
  end

  assign alarm_s   = ($unsigned(32'(final_s)) >= $unsigned(32'(THRESH)));
  assign load_s    = win_end_s & can_load_s;
  assign drop_s    = win_end_s & ~can_load_s;
  assign slot_in_s = {alarm_s, final_s};

  // Window state and sticky drop flag; a drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cyc_r     <= '0;
      hit_cnt_r <= '0;
      dropped_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cyc_r     <= cyc_s;
      hit_cnt_r <= hit_cnt_s;
      if (drop_s) begin
        dropped_r <= 1'b1;
      end else if (clr_dropped) begin
        dropped_r <= 1'b0;
      end
    end
  end

  seq_mon_report_slot #(
    .DATA_W (CNT_W + 1)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .load_data (slot_in_s),
    .ready     (rpt.rpt_ready),
    .valid     (rpt.rpt_valid),
    .data      (slot_q_s),
    .can_load  (can_load_s)
  );

  assign rpt.rpt_count = slot_q_s[CNT_W-1:0];
  assign rpt.rpt_alarm = slot_q_s[CNT_W];
  assign dropped       = dropped_r;

endmodule
